iir_filter: RTL and testbench



---
 rtl/iir_filter_pkg.sv | 45 ++++
 rtl/iir_round_sat.sv | 33 +++
 rtl/iir_filter.sv | 106 ++++++++++
 tb/tb_iir_filter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/iir_filter_pkg.sv
// iir_filter_pkg: default widths, default biquad coefficients and the
// rounding / saturating-narrow helpers shared by the iir_filter datapath.
// The IIR_FILTER_SAT_EN macro selects output saturation (defined) or
// two's-complement wrap (undefined) in iir_round_sat.
package iir_filter_pkg;

    // Default sample, coefficient, fraction and state widths.
    localparam int DEF_DW   = 8;
    localparam int DEF_CW   = 16;
    localparam int DEF_FRAC = 14;
    localparam int DEF_SW   = 32;

    // Default Q2.14 coefficients: unity DC gain, double real pole at z = 0.5.
    localparam int DEF_B0 = 1024;    //  0.0625
    localparam int DEF_B1 = 2048;    //  0.125
    localparam int DEF_B2 = 1024;    //  0.0625
    localparam int DEF_A1 = -16384;  // -1.0
    localparam int DEF_A2 = 4096;    //  0.25

    // Generic wide signed carrier for the helpers; wide enough for any
    // state width this filter is built with.
    typedef logic signed [63:0] wide_t;

    // Round half up: add half an LSB of the result, then floor-shift.
    function automatic wide_t round_half_up(input wide_t v, input int frac);
        wide_t half;
        half = 64'sd1 <<< (frac - 1);
        return (v + half) >>> frac;
    endfunction

    // Clamp a signed value into the range of a dw-bit signed number.
    function automatic wide_t sat_narrow(input wide_t v, input int dw);
        wide_t hi;
        wide_t lo;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/iir_round_sat.sv
// iir_round_sat: converts the extended-precision filter state (Q.FRAC) into
// a DW-bit output sample. Rounds half up, then either clamps to the DW-bit
// range (IIR_FILTER_SAT_EN defined) or keeps the low DW bits (wrap).
// Purely combinational; the caller registers the result.
module iir_round_sat
    import iir_filter_pkg::*;
#(
    parameter int DW   = DEF_DW,
    parameter int SW   = DEF_SW,
    parameter int FRAC = DEF_FRAC
) (
    input  logic signed [SW-1:0] s,
    output logic signed [DW-1:0] y
);

    wide_t s_ext;
    wide_t rounded;
    wide_t narrowed;

    // Round the state to integer sample units and fit it into DW bits.
    always_comb begin
        s_ext   = wide_t'(s);
        rounded = round_half_up(s_ext, FRAC);
`ifdef IIR_FILTER_SAT_EN
        narrowed = sat_narrow(rounded, DW);
`else
        // Wrap build: the truncating cast below drops the high bits.
        narrowed = rounded;
`endif
        y = DW'(narrowed);
    end

endmodule

// File: rtl/iir_filter.sv
// iir_filter: direct-form-I second-order IIR low-pass on a signed DW-bit
// stream, one sample per clock, one cycle of latency, registered output.
//   s[n] = B0*x[n] + B1*x[n-1] + B2*x[n-2] - A1*s[n-1] - A2*s[n-2]
// State is kept in Q.FRAC at SW bits and is never clamped, so a constant
// input settles exactly with no dead-band. Only the output is narrowed,
// with saturation when IIR_FILTER_SAT_EN is defined, wrap otherwise.
// Streaming interface: no valid/ready; x is consumed on every rising edge
// and y carries the result of that edge until the next one.
// Reset: rst_n is synchronous and active-high (1 clears all history).
module iir_filter
    import iir_filter_pkg::*;
#(
    parameter int DW   = DEF_DW,
    parameter int CW   = DEF_CW,
    parameter int FRAC = DEF_FRAC,
    parameter int SW   = DEF_SW,
    parameter int B0   = DEF_B0,
    parameter int B1   = DEF_B1,
    parameter int B2   = DEF_B2,
    parameter int A1   = DEF_A1,
    parameter int A2   = DEF_A2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic signed [DW-1:0] x,
    output logic signed [DW-1:0] y
);

    // Accumulator wide enough for a coefficient times a state word plus
    // headroom for summing the five taps.
    localparam int AW = SW + CW + 2;

    localparam logic signed [AW-1:0] B0_W = AW'(B0);
    localparam logic signed [AW-1:0] B1_W = AW'(B1);
    localparam logic signed [AW-1:0] B2_W = AW'(B2);
    localparam logic signed [AW-1:0] A1_W = AW'(A1);
    localparam logic signed [AW-1:0] A2_W = AW'(A2);

    // Delay lines and the narrowed next output.
    logic signed [DW-1:0] x1;
    logic signed [DW-1:0] x2;
    logic signed [SW-1:0] s1;
    logic signed [SW-1:0] s2;
    logic signed [SW-1:0] s_next;
    logic signed [DW-1:0] y_next;

    // Sign-extended operands and the five tap products.
    logic signed [AW-1:0] x0_w;
    logic signed [AW-1:0] x1_w;
    logic signed [AW-1:0] x2_w;
    logic signed [AW-1:0] s1_w;
    logic signed [AW-1:0] s2_w;
    logic signed [AW-1:0] ff0;
    logic signed [AW-1:0] ff1;
    logic signed [AW-1:0] ff2;
    logic signed [AW-1:0] fb1;
    logic signed [AW-1:0] fb2;
    logic signed [AW-1:0] acc;

    // Compute the new state from the current sample and the history.
    always_comb begin
        x0_w = AW'(x);
        x1_w = AW'(x1);
        x2_w = AW'(x2);
        s1_w = AW'(s1);
        s2_w = AW'(s2);
        // Samples are integers, so feed-forward products are lifted to
        // Q.2FRAC to line up with coefficient*state products.
        ff0 = (B0_W * x0_w) <<< FRAC;
        ff1 = (B1_W * x1_w) <<< FRAC;
        ff2 = (B2_W * x2_w) <<< FRAC;
        fb1 = A1_W * s1_w;
        fb2 = A2_W * s2_w;
        acc = ff0 + ff1 + ff2 - fb1 - fb2;
        // Floor back to Q.FRAC; the truncation to SW bits is intentional.
        s_next = SW'(acc >>> FRAC);
    end

    // Round and narrow the new state to the output width.
    iir_round_sat #(
        .DW   (DW),
        .SW   (SW),
        .FRAC (FRAC)
    ) u_round_sat (
        .s (s_next),
        .y (y_next)
    );

    // Advance the delay lines and register the output; reset drops history.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            x1 <= '0;
            x2 <= '0;
            s1 <= '0;
            s2 <= '0;
            y  <= '0;
        end else begin
            x1 <= x;
            x2 <= x1;
            s1 <= s_next;
            s2 <= s1;
            y  <= y_next;
        end
    end

endmodule

// File: tb/tb_iir_filter.sv
// tb_iir_filter: self-checking bench for iir_filter. A reference model of
// the recurrence produces the expected output per driven sample; results
// are queued and compared one cycle later against the registered output.
module tb_iir_filter;

    localparam int DW = 8;
    localparam int M_B0 = 1024;
    localparam int M_B1 = 2048;
    localparam int M_B2 = 1024;
    localparam int M_A1 = -16384;
    localparam int M_A2 = 4096;

    logic                 clk;
    logic                 rst_n;
    logic signed [DW-1:0] x;
    logic signed [DW-1:0] y;
    logic signed [DW-1:0] x_o;
    logic signed [DW-1:0] y_o;

    int total;
    int bad;
    int last_y;

    logic [DW-1:0] exp_q[$];

    longint m_x1, m_x2, m_s1, m_s2;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    iir_filter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .x     (x),
        .y     (y)
    );

    // Pure-gain instance used to push the output beyond the sample range.
    iir_filter #(
        .B0 (32767),
        .B1 (0),
        .B2 (0),
        .A1 (0),
        .A2 (0)
    ) dut_ovr (
        .clk   (clk),
        .rst_n (rst_n),
        .x     (x_o),
        .y     (y_o)
    );

    // ---------------- reference model ----------------
    task automatic model_step(input int xin, input bit rin, output int ye);
        longint acc;
        longint s;
        longint r;
        if (rin) begin
            m_x1 = 0; m_x2 = 0; m_s1 = 0; m_s2 = 0;
            ye = 0;
            return;
        end
        acc = (M_B0 * xin + M_B1 * m_x1 + M_B2 * m_x2) * 16384
              - M_A1 * m_s1 - M_A2 * m_s2;
        s = acc >>> 14;
        r = (s + 8192) >>> 14;
`ifdef IIR_FILTER_SAT_EN
        if (r > 127) r = 127;
        if (r < -128) r = -128;
`else
        r = ((r + 128) & 255) - 128;
`endif
        m_x2 = m_x1;
        m_x1 = xin;
        m_s2 = m_s1;
        m_s1 = s;
        ye = int'(r);
    endtask

    // ---------------- driver + scoreboard ----------------
    task automatic drive(input int xin, input bit rin);
        int e;
        logic [DW-1:0] ev;
        x     = DW'(xin);
        rst_n = rin;
        model_step(xin, rin, e);
        ev = DW'(e);
        exp_q.push_back(ev);
        @(posedge clk);
        #1;
        ev = exp_q.pop_front();
        total++;
        if (y !== ev) begin
            bad++;
            $display("FAIL y_model: x=%0d rst=%0d got %0d want %0d",
                     xin, rin, $signed(y), $signed(ev));
        end
        last_y = int'($signed(y));
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        for (int i = 0; i < 3; i++) drive(0, 1'b1);
        total++;
        if (y_o !== 8'sd0) begin
            bad++;
            $display("FAIL reset_ovr: got %0d want 0", $signed(y_o));
        end
        // Samples presented during reset must be ignored.
        for (int i = 0; i < 3; i++) drive(100, 1'b1);
        total++;
        if (y !== 8'sd0) begin
            bad++;
            $display("FAIL reset_hold: got %0d want 0", $signed(y));
        end
        for (int i = 0; i < 4; i++) drive(0, 1'b0);
    endtask

    task automatic check_step_start(input string name);
        int want[3];
        want[0] = 6; want[1] = 25; want[2] = 48;
        for (int i = 0; i < 3; i++) begin
            drive(100, 1'b0);
            total++;
            if (last_y != want[i]) begin
                bad++;
                $display("FAIL %s_%0d: got %0d want %0d", name, i, last_y, want[i]);
            end
        end
    endtask

    task automatic test_step_up();
        int prev;
        check_step_start("step_up");
        prev = last_y;
        for (int i = 0; i < 37; i++) begin
            drive(100, 1'b0);
            total++;
            if (last_y < prev) begin
                bad++;
                $display("FAIL step_up_mono: got %0d want >= %0d", last_y, prev);
            end
            prev = last_y;
        end
        for (int i = 0; i < 5; i++) begin
            drive(100, 1'b0);
            total++;
            if (last_y != 100) begin
                bad++;
                $display("FAIL step_up_settle: got %0d want 100", last_y);
            end
        end
    endtask

    task automatic test_step_down();
        int prev;
        prev = last_y;
        for (int i = 0; i < 40; i++) begin
            drive(-50, 1'b0);
            total++;
            if (last_y > prev) begin
                bad++;
                $display("FAIL step_down_mono: got %0d want <= %0d", last_y, prev);
            end
            prev = last_y;
        end
        for (int i = 0; i < 5; i++) begin
            drive(-50, 1'b0);
            total++;
            if (last_y != -50) begin
                bad++;
                $display("FAIL step_down_settle: got %0d want -50", last_y);
            end
        end
    endtask

    task automatic test_impulse();
        drive(0, 1'b1);
        drive(100, 1'b0);
        total++;
        if (last_y != 6) begin
            bad++;
            $display("FAIL impulse_0: got %0d want 6", last_y);
        end
        drive(0, 1'b0);
        total++;
        if (last_y != 19) begin
            bad++;
            $display("FAIL impulse_1: got %0d want 19", last_y);
        end
        for (int i = 0; i < 40; i++) drive(0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive(0, 1'b0);
            total++;
            if (last_y != 0) begin
                bad++;
                $display("FAIL impulse_decay: got %0d want 0", last_y);
            end
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 5; i++) drive(100, 1'b0);
        drive(100, 1'b1);
        total++;
        if (last_y != 0) begin
            bad++;
            $display("FAIL mid_reset: got %0d want 0", last_y);
        end
        check_step_start("mid_reset_restart");
    endtask

    task automatic test_override();
        logic signed [DW-1:0] want;
`ifdef IIR_FILTER_SAT_EN
        want = 8'sd127;
`else
        want = -8'sd56;
`endif
        x_o = 8'sd100;
        for (int i = 0; i < 3; i++) begin
            drive(0, 1'b0);
            total++;
            if (y_o !== want) begin
                bad++;
                $display("FAIL override_gain: got %0d want %0d", $signed(y_o), $signed(want));
            end
        end
        x_o = 8'sd0;
        drive(0, 1'b0);
        total++;
        if (y_o !== 8'sd0) begin
            bad++;
            $display("FAIL override_zero: got %0d want 0", $signed(y_o));
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 300; i++) begin
            drive(int'($urandom_range(0, 255)) - 128, ($urandom_range(0, 49) == 0));
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        total = 0;
        bad   = 0;
        last_y = 0;
        rst_n = 1'b1;
        x     = '0;
        x_o   = '0;
        m_x1 = 0; m_x2 = 0; m_s1 = 0; m_s2 = 0;
        test_reset();
        test_step_up();
        test_step_down();
        test_impulse();
        test_mid_reset();
        test_override();
        test_back_to_back();
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL queue_drain: got %0d want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
